// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared widths, constants and the duty/count type for the PWM peripheral.
// Also holds the compare helper used to turn (count, duty) into a pin level.
package pwm_pkg;

  localparam int PWM_W            = 8;
  localparam int NUM_OUT          = 16;
  localparam int PRESCALE_DEFAULT = 13;

  typedef logic [PWM_W-1:0] pwm_val_t;

  localparam pwm_val_t DUTY_FULL = 8'hFF;
  localparam pwm_val_t COUNT_MAX = 8'hFF;

  // 0xFF is treated as a true 100% so the output never drops for the one
  // count step where count==255.
  function automatic logic pwm_level(input pwm_val_t count, input pwm_val_t duty);
    return (duty == DUTY_FULL) ? 1'b1 : (count < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase
// Prescaler, 8-bit PWM count and duty shadow register shared by all pins.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   count_en     - synchronised run enable; the prescaler holds while low
//   duty_in      - requested duty, sampled only at the 255->0 wrap
//   count        - current PWM count
//   duty_shadow  - duty in force for the current period
//   wrap         - registered one-clk strobe, high in the first count==0 cycle
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     count_en,
  input  pwm_val_t duty_in,
  output pwm_val_t count,
  output pwm_val_t duty_shadow,
  output logic     wrap
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_q, pre_d;
  pwm_val_t    count_q, count_d;
  pwm_val_t    duty_shadow_q, duty_shadow_d;
  logic        wrap_q, wrap_d;
  logic        tick;

  always_comb begin
    tick          = 1'b0;
    pre_d         = pre_q;
    count_d       = count_q;
    wrap_d        = 1'b0;
    duty_shadow_d = duty_shadow_q;

    if (count_en) begin
      tick  = (pre_q == PRE_LAST);
      pre_d = tick ? 16'd0 : pre_q + 16'd1;
    end

    if (tick) begin
      count_d = count_q + 8'd1;
      // Capturing duty only on the wrap keeps every period glitch-free.
      if (count_q == COUNT_MAX) begin
        wrap_d        = 1'b1;
        duty_shadow_d = duty_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= 16'd0;
      count_q       <= '0;
      wrap_q        <= 1'b0;
      duty_shadow_q <= '0;
    end else begin
      pre_q         <= pre_d;
      count_q       <= count_d;
      wrap_q        <= wrap_d;
      duty_shadow_q <= duty_shadow_d;
    end
  end

  assign count       = count_q;
  assign duty_shadow = duty_shadow_q;
  assign wrap        = wrap_q;

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
// Sixteen registered output pins, each forced low, forced high or driven by
// one shared 8-bit PWM waveform, configured from the SPI register block.
// Ports:
//   clk, rst_n           - system clock, asynchronous active-low reset
//   en_reg_out_7_0/15_8  - per-pin output enable
//   en_reg_pwm_7_0/15_8  - per-pin PWM select (only meaningful when enabled)
//   pwm_duty_cycle       - requested duty in 1/256 steps, 0xFF = always high
//   out                  - registered pin outputs
//   pwm_sync             - one-clk pulse aligned with the first out cycle of
//                          each new PWM period
module pwm_peripheral #(
  parameter int PRESCALE = pwm_pkg::PRESCALE_DEFAULT,
  parameter int NUM_OUT  = pwm_pkg::NUM_OUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         en_reg_out_7_0,
  input  logic [7:0]         en_reg_out_15_8,
  input  logic [7:0]         en_reg_pwm_7_0,
  input  logic [7:0]         en_reg_pwm_15_8,
  input  logic [7:0]         pwm_duty_cycle,
  output logic [NUM_OUT-1:0] out,
  output logic               pwm_sync
);

  import pwm_pkg::*;

  logic [1:0]         rst_sync_q, rst_sync_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               pwm_sync_q, pwm_sync_d;
  logic [NUM_OUT-1:0] en_out, en_pwm;
  pwm_val_t           count, duty_shadow;
  logic               wrap;
  logic               pwm;

  // Assert is asynchronous; release ripples through two flops so the
  // timebase never leaves reset on a metastable edge.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_en   (rst_sync_q[1]),
    .duty_in    (pwm_duty_cycle),
    .count      (count),
    .duty_shadow(duty_shadow),
    .wrap       (wrap)
  );

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pwm    = pwm_level(count, duty_shadow);

  // wrap is already one clk behind the count, so registering it here lines
  // it up with the out cycle that shows count==0.
  always_comb begin
    out_d      = '0;
    pwm_sync_d = wrap;
    for (int i = 0; i < NUM_OUT; i++) begin
      out_d[i] = en_out[i] & (~en_pwm[i] | pwm);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      pwm_sync_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      pwm_sync_q <= pwm_sync_d;
    end
  end

  assign out      = out_q;
  assign pwm_sync = pwm_sync_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral
// Self-checking bench for pwm_peripheral. Expected per-period measurements
// are queued when a configuration is applied and popped as each period is
// observed between pwm_sync pulses.
module tb_pwm_peripheral;

  localparam int PRESCALE = 13;
  localparam int PERIOD   = PRESCALE * 256;
  localparam int LIMIT    = 2 * PERIOD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        pwm_sync;

  always #5 clk = ~clk;

  pwm_peripheral #(
    .PRESCALE(PRESCALE),
    .NUM_OUT (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .out            (out),
    .pwm_sync       (pwm_sync)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic popCheck(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] duty);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    pwm_duty_cycle  = duty;
  endtask

  // Advances at least one clk, then waits for the next pwm_sync pulse.
  task automatic waitSync(output int n);
    n = 0;
    while (n < LIMIT) begin
      @(negedge clk);
      n++;
      if (pwm_sync === 1'b1) break;
    end
    if (pwm_sync !== 1'b1) checkOutput("sync_timeout", {31'd0, pwm_sync}, 32'd1);
  endtask

  // Starts on a pwm_sync cycle and samples every cycle up to (not including)
  // the next pwm_sync; optionally rewrites the duty at sample index chg_at.
  task automatic measurePeriod(input int chg_at, input logic [7:0] chg_duty,
                               output int len, output int hi0,
                               output logic [15:0] andv, output logic [15:0] orv);
    len  = 0;
    hi0  = 0;
    andv = '1;
    orv  = '0;
    do begin
      if (len == chg_at) pwm_duty_cycle = chg_duty;
      len++;
      if (out[0] === 1'b1) hi0++;
      andv &= out;
      orv  |= out;
      @(negedge clk);
    end while (pwm_sync !== 1'b1 && len < LIMIT);
  endtask

  int          n, len, hi0;
  logic [15:0] andv, orv;

  initial begin
    applyStimulus(16'h0000, 16'h0000, 8'h80);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out", 32'(out), 32'h0);
    checkOutput("reset_sync", {31'd0, pwm_sync}, 32'd0);

    // Two synchroniser clocks, then 256 ticks, then the output register.
    rst_n = 1'b1;
    pushExpected("release_to_sync", 32'(PERIOD + 3));
    waitSync(n);
    popCheck(32'(n));

    // All pins disabled: out stays low, pwm_sync keeps a steady period.
    for (int k = 0; k < 2; k++) begin
      pushExpected("off_len", 32'(PERIOD));
      pushExpected("off_or", 32'h0);
      measurePeriod(-1, 8'h80, len, hi0, andv, orv);
      popCheck(32'(len));
      popCheck(32'(orv));
    end

    // Static-high pin 0 appears exactly one clk after the write.
    applyStimulus(16'h0001, 16'h0000, 8'h80);
    #1;
    checkOutput("pin0_before_edge", 32'(out), 32'h0);
    pushExpected("pin0_static", 32'h0001);
    @(negedge clk);
    popCheck(32'(out));

    // 50% PWM on pin 0 with the rest forced high.
    applyStimulus(16'hFFFF, 16'h0001, 8'h80);
    waitSync(n);
    pushExpected("d80_len", 32'(PERIOD));
    pushExpected("d80_hi", 32'(128 * PRESCALE));
    pushExpected("d80_others", 32'h7FFF);
    measurePeriod(-1, 8'h80, len, hi0, andv, orv);
    popCheck(32'(len));
    popCheck(32'(hi0));
    popCheck(32'(andv[15:1]));

    // Duty 0x00: constant low.
    applyStimulus(16'hFFFF, 16'h0001, 8'h00);
    waitSync(n);
    pushExpected("d00_hi", 32'h0);
    measurePeriod(-1, 8'h00, len, hi0, andv, orv);
    popCheck(32'(hi0));

    // Duty 0xFF: high for two back-to-back periods including the wrap.
    applyStimulus(16'hFFFF, 16'h0001, 8'hFF);
    waitSync(n);
    for (int k = 0; k < 2; k++) begin
      pushExpected("dff_hi", 32'(PERIOD));
      measurePeriod(-1, 8'hFF, len, hi0, andv, orv);
      popCheck(32'(hi0));
    end

    // Duty 0x01: one count step high.
    applyStimulus(16'hFFFF, 16'h0001, 8'h01);
    waitSync(n);
    pushExpected("d01_hi", 32'(PRESCALE));
    measurePeriod(-1, 8'h01, len, hi0, andv, orv);
    popCheck(32'(hi0));

    // Mid-period duty change only lands at the next wrap.
    applyStimulus(16'hFFFF, 16'h0001, 8'h40);
    waitSync(n);
    pushExpected("chg_old_hi", 32'(64 * PRESCALE));
    pushExpected("chg_new_hi", 32'(192 * PRESCALE));
    pushExpected("chg_new_len", 32'(PERIOD));
    measurePeriod(100 * PRESCALE, 8'hC0, len, hi0, andv, orv);
    popCheck(32'(hi0));
    measurePeriod(-1, 8'hC0, len, hi0, andv, orv);
    popCheck(32'(hi0));
    popCheck(32'(len));

    // Asynchronous reset while every pin is high.
    applyStimulus(16'hFFFF, 16'h0000, 8'hC0);
    pushExpected("pre_reset_high", 32'hFFFF);
    @(negedge clk);
    popCheck(32'(out));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out", 32'(out), 32'h0);
    checkOutput("async_reset_sync", {31'd0, pwm_sync}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pushExpected("rerelease_to_sync", 32'(PERIOD + 3));
    pushExpected("rerelease_len", 32'(PERIOD));
    pushExpected("rerelease_all", 32'hFFFF);
    waitSync(n);
    popCheck(32'(n));
    measurePeriod(-1, 8'hC0, len, hi0, andv, orv);
    popCheck(32'(len));
    popCheck(32'(andv));

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
